// File: rtl/dequantize.sv
// ============================================================================
// Module   : dequantize
// Brief    : Serial midpoint reconstruction of an N-bit unsigned code onto an
//            18-bit full-scale value.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dequantize (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  Nquant,
    input  logic [17:0] datain,
    input  logic        endatain,
    output logic [17:0] dataout,
    output logic        dataready,
    output logic        busy
);

    localparam logic [4:0]  C_WIDTH    = 5'd18;
    localparam logic [17:0] C_FULL_MSK = 18'h3FFFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        OFFSET = 2'd2
    } state_t;

    state_t      state;
    state_t      next_state;

    logic [17:0] sr;
    logic [4:0]  cnt;
    logic [4:0]  shamt;

    logic [4:0]  n_bits;
    logic [4:0]  shift_in;
    logic [17:0] code;
    logic [4:0]  cnt_next;
    logic [17:0] half_lsb;

    // Clamp the requested width to 1..18 and derive the left-justifying shift.
    always_comb begin
        if (Nquant == 5'd0) begin
            n_bits = 5'd1;
        end else if (Nquant >= C_WIDTH) begin
            n_bits = C_WIDTH;
        end else begin
            n_bits = Nquant;
        end
    end

    assign shift_in = C_WIDTH - n_bits;
    assign code     = datain & (C_FULL_MSK >> shift_in);
    assign cnt_next = cnt + 5'd1;
    assign half_lsb = (shamt == 5'd0) ? 18'd0 : (18'd1 << (shamt - 5'd1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (endatain) begin
                    next_state = (shift_in != 5'd0) ? SHIFT : OFFSET;
                end
            end
            SHIFT: begin
                if (cnt_next == shamt) begin
                    next_state = OFFSET;
                end
            end
            OFFSET: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath: code is loaded in IDLE and shifted one place per SHIFT cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sr        <= 18'd0;
            cnt       <= 5'd0;
            shamt     <= 5'd0;
            dataout   <= 18'h00000;
            dataready <= 1'b0;
        end else begin
            dataready <= 1'b0;
            case (state)
                IDLE: begin
                    if (endatain) begin
                        sr    <= code;
                        shamt <= shift_in;
                        cnt   <= 5'd0;
                    end
                end
                SHIFT: begin
                    sr  <= sr << 1;
                    cnt <= cnt_next;
                end
                OFFSET: begin
                    dataout   <= sr | half_lsb;
                    dataready <= 1'b1;
                end
                default: begin
                    sr <= sr;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dequantize.sv
// ============================================================================
// Module   : tb_dequantize
// Brief    : Directed-vector bench for dequantize with a cycle-count model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dequantize;

    logic        clock;
    logic        reset;
    logic [4:0]  Nquant;
    logic [17:0] datain;
    logic        endatain;
    logic [17:0] dataout;
    logic        dataready;
    logic        busy;

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit check_en  = 1'b0;

    dequantize dut (
        .clock     (clock),
        .reset     (reset),
        .Nquant    (Nquant),
        .datain    (datain),
        .endatain  (endatain),
        .dataout   (dataout),
        .dataready (dataready),
        .busy      (busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference value straight from the arithmetic definition.
    function automatic logic [17:0] ref_value(input int nq, input int din);
        int n, s, c, r;
        n = (nq == 0) ? 1 : ((nq >= 18) ? 18 : nq);
        s = 18 - n;
        c = din % (1 << n);
        r = c * (1 << s) + ((s > 0) ? (1 << (s - 1)) : 0);
        return r[17:0];
    endfunction

    function automatic int ref_shift(input int nq);
        int n;
        n = (nq == 0) ? 1 : ((nq >= 18) ? 18 : nq);
        return 18 - n;
    endfunction

    // Model: a request occupies the block for S+1 edges, result appears on the last.
    int          m_left    = 0;
    logic [17:0] m_val     = '0;
    logic [17:0] exp_out   = '0;
    logic        exp_ready = 1'b0;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_left    <= 0;
            m_val     <= '0;
            exp_out   <= '0;
            exp_ready <= 1'b0;
        end else begin
            exp_ready <= 1'b0;
            if (m_left == 0) begin
                if (endatain) begin
                    m_left <= ref_shift(int'(Nquant)) + 1;
                    m_val  <= ref_value(int'(Nquant), int'(datain));
                end
            end else begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    exp_out   <= m_val;
                    exp_ready <= 1'b1;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (check_en) begin
            check("cyc_dataready", {31'd0, dataready}, {31'd0, exp_ready});
            check("cyc_busy", {31'd0, busy}, {31'd0, (m_left != 0)});
            check("cyc_dataout", {14'd0, dataout}, {14'd0, exp_out});
        end
    end

    task automatic request(input logic [4:0] nq, input logic [17:0] din);
        @(negedge clock);
        Nquant   = nq;
        datain   = din;
        endatain = 1'b1;
        @(negedge clock);
        endatain = 1'b0;
    endtask

    // Called at the negedge after the acceptance edge; expects first pulse S+1 edges later.
    task automatic wait_result(input string name, input int lat, input logic [17:0] val);
        int seen;
        seen = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clock);
            if (dataready && seen == 0) begin
                seen = i;
                check({name, "_value"}, {14'd0, dataout}, {14'd0, val});
                break;
            end
        end
        if (seen == 0) begin
            $display("FAIL %s_timeout: no dataready within 40 cycles (expected %0d)", name, lat);
            total_cnt++;
        end else begin
            check({name, "_latency"}, seen, lat);
        end
    endtask

    initial begin
        int pulses;
        int first;
        reset    = 1'b1;
        Nquant   = 5'd0;
        datain   = 18'd0;
        endatain = 1'b0;

        // Hand-computed pins on the reference model itself.
        check("model_16_5", {14'd0, ref_value(16, 5)}, 32'h00016);
        check("model_1_ff", {14'd0, ref_value(1, 'h3FFFF)}, 32'h30000);
        check("model_17_0", {14'd0, ref_value(17, 0)}, 32'h00001);

        repeat (2) @(negedge clock);
        check("reset_dataout", {14'd0, dataout}, 32'h0);
        check("reset_dataready", {31'd0, dataready}, 32'h0);
        check("reset_busy", {31'd0, busy}, 32'h0);
        reset = 1'b0;
        check_en = 1'b1;

        request(5'd16, 18'h00005);
        wait_result("n16", 3, 18'h00016);

        request(5'd18, 18'h2ABCD);
        wait_result("n18", 1, 18'h2ABCD);
        request(5'd20, 18'h2ABCD);
        wait_result("n20", 1, 18'h2ABCD);

        request(5'd1, 18'h3FFFF);
        wait_result("n1", 18, 18'h30000);
        request(5'd0, 18'h3FFFF);
        wait_result("n0", 18, 18'h30000);

        // Extra requests and input changes while busy must be ignored.
        request(5'd10, 18'h3FC01);
        pulses = 0;
        first  = 0;
        for (int i = 1; i <= 20; i++) begin
            if (i == 1) begin
                endatain = 1'b1;
                Nquant   = 5'd4;
                datain   = 18'h3FFFF;
            end
            if (i == 3) endatain = 1'b0;
            @(negedge clock);
            if (dataready) begin
                pulses++;
                if (first == 0) begin
                    first = i;
                    check("n10_value", {14'd0, dataout}, 32'h00180);
                end
            end
        end
        check("n10_pulses", pulses, 1);
        check("n10_latency", first, 9);

        // Asynchronous reset in the middle of a long SHIFT phase.
        request(5'd4, 18'h00005);
        repeat (3) @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("arst_dataout", {14'd0, dataout}, 32'h0);
        check("arst_busy", {31'd0, busy}, 32'h0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (dataready) pulses++;
        end
        check("arst_no_ready", pulses, 0);
        request(5'd16, 18'h00003);
        wait_result("post_rst", 3, 18'h0000E);

        // Back-to-back: second request accepted on the dataready edge.
        request(5'd17, 18'h00001);
        @(negedge clock);
        @(negedge clock);
        check("b2b_first_ready", {31'd0, dataready}, 32'h1);
        check("b2b_first_value", {14'd0, dataout}, 32'h00003);
        datain   = 18'h00000;
        endatain = 1'b1;
        @(negedge clock);
        endatain = 1'b0;
        check("b2b_gap_ready", {31'd0, dataready}, 32'h0);
        check("b2b_gap_busy", {31'd0, busy}, 32'h1);
        @(negedge clock);
        @(negedge clock);
        check("b2b_second_ready", {31'd0, dataready}, 32'h1);
        check("b2b_second_value", {14'd0, dataout}, 32'h00001);

        repeat (4) @(negedge clock);
        check("hold_dataout", {14'd0, dataout}, 32'h00001);
        check_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

`default_nettype wire
